// File: rtl/sha256_pkg.sv
// sha256_pkg: shared states, initial hash value and default timeout for the SHA-256 sequencer
package sha256_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE, S_ERR} state_e;
  localparam logic [255:0] H0 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam int TIMEOUT_DEF = 128;
endpackage

// File: rtl/sha256_seq_timer.sv
// seq_timer: counts enabled cycles since clear and flags the last cycle before the limit
module seq_timer #(
  parameter int MAX = 128,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
  assign expired = en && (cnt_q == W'(MAX - 1));
  // cycle counter, cleared on entry to a wait period
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sha256_seq.sv
// sha256_seq: feeds padded blocks to an external SHA-256 core and chains results into a digest
module sha256_seq
  import sha256_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_valid,
  input  logic [511:0]      blk_data,
  input  logic              blk_last,
  output logic              blk_ready,
  output logic [255:0]      core_H_in,
  output logic [511:0]      core_M_in,
  output logic              core_input_valid,
  input  logic [255:0]      core_H_out,
  input  logic              core_output_valid,
  output logic [255:0]      digest,
  output logic              digest_valid,
  input  logic              digest_ready,
  output logic              err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  blk_cnt
);
  state_e state_q, state_d;
  logic [511:0] blk_q, blk_d;
  logic last_q, last_d;
  logic [255:0] chain_q, chain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic expired;
  seq_timer #(.MAX(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state_q == S_LOAD),
    .en(state_q == S_WAIT),
    .expired(expired)
  );
  assign blk_ready = state_q == S_IDLE;
  assign core_input_valid = state_q == S_LOAD;
  assign core_M_in = blk_q;
  assign core_H_in = chain_q;
  assign digest = chain_q;
  assign digest_valid = state_q == S_DONE;
  assign err = state_q == S_ERR;
  assign blk_cnt = cnt_q;
  // sequencing: accept block, start core, collect result (valid beats timeout), hand off digest
  always_comb begin
    state_d = state_q;
    blk_d = blk_q;
    last_d = last_q;
    chain_d = chain_q;
    cnt_d = cnt_q;
    unique case (state_q)
      S_IDLE: if (blk_valid) begin
        blk_d = blk_data;
        last_d = blk_last;
        state_d = S_LOAD;
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: if (core_output_valid) begin
        chain_d = core_H_out;
        cnt_d = cnt_q + CNT_W'(1);
        state_d = last_q ? S_DONE : S_IDLE;
      end else if (expired) state_d = S_ERR;
      S_DONE: if (digest_ready) begin
        state_d = S_IDLE;
        chain_d = H0;
        cnt_d = '0;
      end
      S_ERR: if (err_clr) begin
        state_d = S_IDLE;
        chain_d = H0;
        cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any message in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      blk_q <= '0;
      last_q <= 1'b0;
      chain_q <= H0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q <= blk_d;
      last_q <= last_d;
      chain_q <= chain_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_sha256_seq.sv
// tb_sha256_seq: directed checks of the sequencer against a behavioural SHA-256 core stub
module tb_sha256_seq;
  localparam logic [255:0] H0 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] B1 = {448'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071, 64'h80000000_00000000};
  localparam logic [511:0] B2 = {448'h0, 64'h1c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam int LAT = 5;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  logic clk = 1'b0, rst = 1'b1;
  logic blk_valid = 1'b0, blk_last = 1'b0, blk_ready;
  logic [511:0] blk_data = '0;
  logic [255:0] core_H_in, core_H_out, digest;
  logic [511:0] core_M_in;
  logic core_input_valid, core_output_valid, digest_valid, err;
  logic digest_ready = 1'b0, err_clr = 1'b0;
  logic [15:0] blk_cnt;
  logic stub_ov = 1'b0, stub_mute = 1'b0, spur = 1'b0, busy = 1'b0, hold_chk = 1'b1;
  logic [255:0] stub_h = '0, sh = '0;
  logic [511:0] sm = '0;
  int lat = 0, pulses = 0, checks = 0, failures = 0;
  assign core_output_valid = stub_ov | spur;
  assign core_H_out = spur ? 256'hdead_beef : stub_h;
  sha256_seq dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last),
    .blk_ready(blk_ready), .core_H_in(core_H_in), .core_M_in(core_M_in),
    .core_input_valid(core_input_valid), .core_H_out(core_H_out),
    .core_output_valid(core_output_valid), .digest(digest), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .err(err), .err_clr(err_clr), .blk_cnt(blk_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] compress(input logic [255:0] hv, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = hv;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[255:224] + a, hv[223:192] + b, hv[191:160] + c, hv[159:128] + d,
            hv[127:96] + e, hv[95:64] + f, hv[63:32] + g, hv[31:0] + hh};
  endfunction
  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // core stub: latch operands on the start pulse, answer LAT cycles later, verify operands held
  always @(negedge clk) begin
    stub_ov = 1'b0;
    if (core_input_valid && !busy) begin
      busy = 1'b1; lat = 0; sh = core_H_in; sm = core_M_in; pulses++;
    end else if (busy) begin
      if (lat == LAT) begin
        busy = 1'b0;
        if (hold_chk) begin
          chk("m_hold", core_M_in, sm);
          chk("h_hold", {256'h0, core_H_in}, {256'h0, sh});
        end
        if (!stub_mute) begin stub_ov = 1'b1; stub_h = compress(sh, sm); end
      end else lat++;
    end
  end
  task automatic send(input logic [511:0] d, input logic l);
    int i = 0;
    @(negedge clk);
    blk_valid = 1'b1; blk_data = d; blk_last = l;
    while (!blk_ready && i < 300) begin @(negedge clk); i++; end
    chk("accept", {511'h0, blk_ready}, 512'h1);
    @(posedge clk); #1;
    blk_valid = 1'b0;
  endtask
  task automatic wait_dv();
    int i = 0;
    @(negedge clk);
    while (!digest_valid && i < 300) begin @(negedge clk); i++; end
    chk("digest_valid", {511'h0, digest_valid}, 512'h1);
  endtask
  task automatic ack();
    @(negedge clk); digest_ready = 1'b1;
    @(posedge clk); #1; digest_ready = 1'b0;
  endtask
  initial begin
    logic [255:0] d0;
    int bad, i, p0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {511'h0, blk_ready}, 512'h1);
    chk("rst_civ", {511'h0, core_input_valid}, 512'h0);
    chk("rst_dv", {511'h0, digest_valid}, 512'h0);
    chk("rst_err", {511'h0, err}, 512'h0);
    chk("rst_digest", {256'h0, digest}, {256'h0, H0});
    chk("rst_cnt", {496'h0, blk_cnt}, 512'h0);
    rst = 1'b0;
    pulses = 0;
    send(ABC, 1'b1);
    wait_dv();
    chk("abc_pulses", 512'(pulses), 512'd1);
    chk("abc_digest", {256'h0, digest}, {256'h0, D_ABC});
    chk("abc_cnt", {496'h0, blk_cnt}, 512'd1);
    d0 = digest; bad = 0; p0 = pulses;
    blk_valid = 1'b1; blk_data = B1; blk_last = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (digest !== d0 || blk_ready !== 1'b0 || digest_valid !== 1'b1) bad++;
    end
    blk_valid = 1'b0;
    chk("hold_stable", 512'(bad), 512'd0);
    chk("hold_no_accept", 512'(pulses), 512'(p0));
    ack();
    @(negedge clk);
    chk("ack_ready", {511'h0, blk_ready}, 512'h1);
    chk("ack_cnt", {496'h0, blk_cnt}, 512'd0);
    chk("ack_chain", {256'h0, digest}, {256'h0, H0});
    send(ABC, 1'b1);
    wait_dv();
    chk("abc2_digest", {256'h0, digest}, {256'h0, D_ABC});
    chk("abc2_cnt", {496'h0, blk_cnt}, 512'd1);
    ack();
    pulses = 0;
    send(B1, 1'b0);
    i = 0;
    @(negedge clk);
    while (!blk_ready && i < 300) begin @(negedge clk); i++; end
    chk("mid_ready", {511'h0, blk_ready}, 512'h1);
    chk("mid_cnt", {496'h0, blk_cnt}, 512'd1);
    d0 = digest;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_chain", {256'h0, digest}, {256'h0, d0});
    chk("spur_cnt", {496'h0, blk_cnt}, 512'd1);
    chk("spur_ready", {511'h0, blk_ready}, 512'h1);
    chk("spur_civ", {511'h0, core_input_valid}, 512'h0);
    send(B2, 1'b1);
    wait_dv();
    chk("two_pulses", 512'(pulses), 512'd2);
    chk("two_digest", {256'h0, digest}, {256'h0, D_TWO});
    chk("two_cnt", {496'h0, blk_cnt}, 512'd2);
    ack();
    stub_mute = 1'b1;
    send(ABC, 1'b1);
    @(negedge clk);
    chk("to_load", {511'h0, core_input_valid}, 512'h1);
    repeat (128) @(posedge clk);
    #1 chk("to_early", {511'h0, err}, 512'h0);
    @(posedge clk);
    #1 chk("to_err", {511'h0, err}, 512'h1);
    chk("to_ready", {511'h0, blk_ready}, 512'h0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("clr_err", {511'h0, err}, 512'h0);
    chk("clr_ready", {511'h0, blk_ready}, 512'h1);
    chk("clr_cnt", {496'h0, blk_cnt}, 512'd0);
    stub_mute = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    hold_chk = 1'b0;
    send(ABC, 1'b1);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ready", {511'h0, blk_ready}, 512'h1);
    chk("mid_rst_civ", {511'h0, core_input_valid}, 512'h0);
    chk("mid_rst_err", {511'h0, err}, 512'h0);
    chk("mid_rst_digest", {256'h0, digest}, {256'h0, H0});
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("late_ready", {511'h0, blk_ready}, 512'h1);
    chk("late_cnt", {496'h0, blk_cnt}, 512'd0);
    chk("late_chain", {256'h0, digest}, {256'h0, H0});
    chk("late_dv", {511'h0, digest_valid}, 512'h0);
    hold_chk = 1'b1;
    send(ABC, 1'b1);
    wait_dv();
    chk("post_rst_digest", {256'h0, digest}, {256'h0, D_ABC});
    chk("post_rst_cnt", {496'h0, blk_cnt}, 512'd1);
    ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
